div_unit_mc: RTL

//   Iterative RV32M divider (DIV/DIVU/REM/REMU) for the multicycle core. It sits between the
//   ALU operand-select muxes (srcA/srcB) and the result-select mux. The control FSM holds
//   the EXECUTE state until ready pulses. Restoring radix-2 algorithm, one quotient bit per cycle.

---
 rtl/kianv_div_pkg.sv | 27 ++
 rtl/div_unit_mc_div_step.sv | 36 +++
 rtl/div_unit_mc.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/kianv_div_pkg.sv
// Shared types and helpers for the multicycle RV32M divider.
package kianv_div_pkg;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } div_state_t;

    // Signed variants work on operand magnitudes and fix signs at the end.
    function automatic logic is_signed(input div_op_t op);
        return (op == DIV) || (op == REM);
    endfunction

    // Remainder ops return the remainder register instead of the quotient.
    function automatic logic wants_rem(input div_op_t op);
        return (op == REM) || (op == REMU);
    endfunction

endpackage

// File: rtl/div_unit_mc_div_step.sv
// One restoring radix-2 division step: shift a quotient bit into the
// partial remainder and subtract the divisor when it fits.
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH:0]   rem_o,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH:0] shifted_s;
    logic [WIDTH:0] dvs_ext_s;
    logic [WIDTH:0] diff_s;
    logic           unused_s;

    // The partial remainder is always below the divisor, so its top bit is
    // zero on entry and is shifted out here.
    assign shifted_s = {rem_i[WIDTH-1:0], q_i[WIDTH-1]};
    assign dvs_ext_s = {1'b0, divisor_i};
    assign diff_s    = shifted_s - dvs_ext_s;
    assign unused_s  = rem_i[WIDTH];

    // Keep the difference when the divisor fits, otherwise restore.
    always_comb begin
        if (shifted_s >= dvs_ext_s) begin
            rem_o = diff_s;
            q_o   = {q_i[WIDTH-2:0], 1'b1};
        end else begin
            rem_o = shifted_s;
            q_o   = {q_i[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_unit_mc.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU) for the multicycle core.
// One quotient bit per cycle; divide-by-zero and signed overflow are
// resolved immediately without iterating.
module div_unit_mc
    import kianv_div_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             ready,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    div_state_t       state_q, state_d;
    div_op_t          op_q, op_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CW-1:0]    count_q, count_d;
    logic             neg_q_q, neg_q_d;
    logic             neg_r_q, neg_r_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             busy_q, busy_d;
    logic             ready_q, ready_d;

    logic [WIDTH-1:0] one_s;
    logic [CW-1:0]    cnt_one_s;
    logic [WIDTH-1:0] int_min_s;
    div_op_t          op_in_s;
    logic             sgn_in_s;
    logic             a_neg_s, b_neg_s;
    logic [WIDTH-1:0] a_mag_s, b_mag_s;
    logic             div_zero_s, ovf_s;
    logic [WIDTH:0]   step_rem_s;
    logic [WIDTH-1:0] step_q_s;
    logic [WIDTH-1:0] q_fix_s, r_fix_s;

    assign one_s     = {{(WIDTH-1){1'b0}}, 1'b1};
    assign cnt_one_s = {{(CW-1){1'b0}}, 1'b1};
    assign int_min_s = {1'b1, {(WIDTH-1){1'b0}}};

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .q_i       (q_q),
        .divisor_i (dvs_q),
        .rem_o     (step_rem_s),
        .q_o       (step_q_s)
    );

    // Operand magnitudes and special-case detection for an incoming request.
    always_comb begin
        op_in_s    = div_op_t'(op);
        sgn_in_s   = is_signed(op_in_s);
        a_neg_s    = sgn_in_s & dividend[WIDTH-1];
        b_neg_s    = sgn_in_s & divisor[WIDTH-1];
        a_mag_s    = a_neg_s ? (~dividend + one_s) : dividend;
        b_mag_s    = b_neg_s ? (~divisor + one_s) : divisor;
        div_zero_s = (divisor == {WIDTH{1'b0}});
        ovf_s      = sgn_in_s && (dividend == int_min_s) && (divisor == {WIDTH{1'b1}});
    end

    // Sign correction of the final step, folded into the DONE-entry cycle.
    always_comb begin
        q_fix_s = neg_q_q ? (~step_q_s + one_s) : step_q_s;
        r_fix_s = neg_r_q ? (~step_rem_s[WIDTH-1:0] + one_s) : step_rem_s[WIDTH-1:0];
    end

    // Next-state, datapath and output logic of the divider FSM.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        q_d      = q_q;
        rem_d    = rem_q;
        dvs_d    = dvs_q;
        count_d  = count_q;
        neg_q_d  = neg_q_q;
        neg_r_d  = neg_r_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d = op_in_s;
                    if (div_zero_s) begin
                        result_d = wants_rem(op_in_s) ? dividend : {WIDTH{1'b1}};
                        state_d  = DONE;
                    end else if (ovf_s) begin
                        result_d = wants_rem(op_in_s) ? {WIDTH{1'b0}} : int_min_s;
                        state_d  = DONE;
                    end else begin
                        q_d     = a_mag_s;
                        rem_d   = {(WIDTH+1){1'b0}};
                        dvs_d   = b_mag_s;
                        count_d = CW'(WIDTH - 1);
                        neg_q_d = a_neg_s ^ b_neg_s;
                        neg_r_d = a_neg_s;
                        state_d = CALC;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                q_d   = step_q_s;
                rem_d = step_rem_s;
                if (count_q == {CW{1'b0}}) begin
                    result_d = wants_rem(op_q) ? r_fix_s : q_fix_s;
                    state_d  = DONE;
                end else begin
                    count_d = count_q - cnt_one_s;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d  = (state_d != IDLE);
        ready_d = (state_d == DONE);
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= IDLE;
            op_q     <= DIV;
            q_q      <= {WIDTH{1'b0}};
            rem_q    <= {(WIDTH+1){1'b0}};
            dvs_q    <= {WIDTH{1'b0}};
            count_q  <= {CW{1'b0}};
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            result_q <= {WIDTH{1'b0}};
            busy_q   <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            q_q      <= q_d;
            rem_q    <= rem_d;
            dvs_q    <= dvs_d;
            count_q  <= count_d;
            neg_q_q  <= neg_q_d;
            neg_r_q  <= neg_r_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            ready_q  <= ready_d;
        end
    end

    assign busy   = busy_q;
    assign ready  = ready_q;
    assign result = result_q;

endmodule
